// File: rtl/timer_digit_loader_if.sv
// Keypad-entry bus: control/keypad inputs toward the loader, BCD digits and status back.
interface timer_digit_loader_if;
    logic       enable;
    logic       clear_entry;
    logic [9:0] keypad;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       key_valid;
    logic       entry_zero;

    modport master (
        output enable, clear_entry, keypad,
        input  sec_ones, sec_tens, min_ones, min_tens, key_valid, entry_zero
    );

    modport slave (
        input  enable, clear_entry, keypad,
        output sec_ones, sec_tens, min_ones, min_tens, key_valid, entry_zero
    );
endinterface

// File: rtl/timer_digit_loader.sv
// Debounces the 10-key keypad and shifts one BCD digit per press into a four-digit MM:SS register.
module timer_digit_loader #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                 clk,
    input logic                 reset,
    timer_digit_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [7:0] DC = 8'(DEBOUNCE_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]  code_q, code_d;
    logic [15:0] entry_q, entry_d;
    logic        key_valid_q, entry_zero_q;
    logic        accept;
    logic [3:0]  pop, idx;
    logic        smp_valid, smp_none;

    // Classify the sample: popcount plus index of the (last) set bit.
    always_comb begin
        pop = '0;
        idx = '0;
        for (int i = 0; i < 10; i++) begin
            if (bus.keypad[i]) begin
                pop = pop + 4'd1;
                idx = 4'(i);
            end
        end
        smp_valid = (pop == 4'd1);
        smp_none  = (pop == 4'd0);
    end

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        accept  = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (smp_valid) begin
                        code_d  = idx;
                        cnt_d   = 8'd1;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (smp_valid && idx == code_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DC) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end
                    end else if (smp_valid) begin
                        code_d = idx;
                        cnt_d  = 8'd1;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (smp_none) begin
                        cnt_d   = 8'd1;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (smp_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DC) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Clear wins over a same-edge accept; the FSM still moves on so the key is not taken twice.
    always_comb begin
        entry_d = entry_q;
        if (bus.clear_entry)
            entry_d = '0;
        else if (accept)
            entry_d = {entry_q[11:0], code_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            code_q       <= '0;
            entry_q      <= '0;
            key_valid_q  <= 1'b0;
            entry_zero_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            entry_q      <= entry_d;
            key_valid_q  <= accept & ~bus.clear_entry;
            entry_zero_q <= (entry_d == 16'h0000);
        end
    end

    assign bus.sec_ones   = entry_q[3:0];
    assign bus.sec_tens   = entry_q[7:4];
    assign bus.min_ones   = entry_q[11:8];
    assign bus.min_tens   = entry_q[15:12];
    assign bus.key_valid  = key_valid_q;
    assign bus.entry_zero = entry_zero_q;
endmodule

// File: tb/tb_timer_digit_loader.sv
// Directed plus randomized bench for timer_digit_loader against a sample-window reference model.
module tb_timer_digit_loader;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    timer_digit_loader_if bus();

    timer_digit_loader #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: a key is taken when the last DC samples are one identical key and the
    // loader is armed; it re-arms once the last DC samples are all empty.
    logic [15:0] m_entry;
    logic        m_kv;
    logic        m_ez;
    bit          m_armed;
    int          hist[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          kv_count = 0;

    function automatic int classify(input logic [9:0] k);
        int n;
        int d;
        n = 0;
        d = 0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) begin
                n++;
                d = i;
            end
        end
        if (n == 0) return -1;
        if (n > 1)  return -2;
        return d;
    endfunction

    task automatic model_edge();
        int s;
        int key;
        bit acc;
        bit all;
        s   = classify(bus.keypad);
        acc = 0;
        key = 0;
        if (reset) begin
            m_entry = '0;
            m_kv    = 0;
            m_armed = 1;
            hist.delete();
        end else if (!bus.enable) begin
            m_kv    = 0;
            m_armed = 1;
            hist.delete();
            if (bus.clear_entry) m_entry = '0;
        end else begin
            hist.push_back(s);
            if (hist.size() > DC) void'(hist.pop_front());
            if (hist.size() == DC) begin
                all = 1;
                if (m_armed) begin
                    foreach (hist[i]) if (hist[i] < 0 || hist[i] != hist[0]) all = 0;
                    if (all) begin
                        acc     = 1;
                        key     = hist[0];
                        m_armed = 0;
                        hist.delete();
                    end
                end else begin
                    foreach (hist[i]) if (hist[i] != -1) all = 0;
                    if (all) begin
                        m_armed = 1;
                        hist.delete();
                    end
                end
            end
            if (bus.clear_entry) begin
                m_entry = '0;
                m_kv    = 0;
            end else if (acc) begin
                m_entry = {m_entry[11:0], 4'(key)};
                m_kv    = 1;
            end else begin
                m_kv = 0;
            end
        end
        m_ez = (m_entry == 16'h0000);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic check_all();
        check("digits",     digits(),             m_entry);
        check("key_valid",  16'(bus.key_valid),   16'(m_kv));
        check("entry_zero", 16'(bus.entry_zero),  16'(m_ez));
    endtask

    task automatic tick(input logic [9:0] kp, input bit en, input bit clr, input bit rs);
        bus.keypad      = kp;
        bus.enable      = en;
        bus.clear_entry = clr;
        reset           = rs;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (bus.key_valid === 1'b1) kv_count++;
    endtask

    task automatic hold(input logic [9:0] kp, input int n, input bit en);
        for (int i = 0; i < n; i++) tick(kp, en, 1'b0, 1'b0);
    endtask

    task automatic press(input int d);
        hold(10'(1 << d), 6, 1'b1);
        hold(10'h000, 5, 1'b1);
    endtask

    initial begin
        logic [9:0] kp;
        int         dur;
        bit         en;
        bus.keypad      = '0;
        bus.enable      = 1'b1;
        bus.clear_entry = 1'b0;
        reset           = 1'b1;
        m_entry = '0; m_kv = 0; m_ez = 1; m_armed = 1;

        // Reset with key 5 already down; accepted four edges after release.
        tick(10'h020, 1'b1, 1'b0, 1'b1);
        tick(10'h020, 1'b1, 1'b0, 1'b1);
        check("rst_digits", digits(), 16'h0000);
        check("rst_ez", 16'(bus.entry_zero), 16'd1);
        check("rst_kv", 16'(bus.key_valid), 16'd0);
        hold(10'h020, 3, 1'b1);
        check("rst_no_early", 16'(bus.key_valid), 16'd0);
        tick(10'h020, 1'b1, 1'b0, 1'b0);
        check("rst_accept_kv", 16'(bus.key_valid), 16'd1);
        check("rst_accept_d", digits(), 16'h0005);
        hold(10'h000, 5, 1'b1);

        // Single press from a cleared register.
        tick(10'h000, 1'b1, 1'b0, 1'b1);
        kv_count = 0;
        hold(10'h020, 3, 1'b1);
        check("sp_ez_before", 16'(bus.entry_zero), 16'd1);
        tick(10'h020, 1'b1, 1'b0, 1'b0);
        check("sp_kv", 16'(bus.key_valid), 16'd1);
        check("sp_sec_ones", 16'(bus.sec_ones), 16'd5);
        check("sp_ez_after", 16'(bus.entry_zero), 16'd0);
        hold(10'h020, 2, 1'b1);
        hold(10'h000, 5, 1'b1);
        check("sp_kv_count", 16'(kv_count), 16'd1);

        // Entry sequence.
        tick(10'h000, 1'b1, 1'b1, 1'b0);
        press(1); press(3); press(0); press(0);
        check("seq_1300", digits(), 16'h1300);
        press(7);
        check("seq_3007", digits(), 16'h3007);

        // Bounce, multi-key, long hold.
        hold(10'h004, 3, 1'b1);
        hold(10'h000, 5, 1'b1);
        check("bounce", digits(), 16'h3007);
        hold(10'h014, 10, 1'b1);
        hold(10'h000, 5, 1'b1);
        check("multi", digits(), 16'h3007);
        kv_count = 0;
        hold(10'h100, 50, 1'b1);
        hold(10'h000, 5, 1'b1);
        check("long_kv", 16'(kv_count), 16'd1);
        check("long_d", digits(), 16'h0078);

        // Release glitch.
        kv_count = 0;
        hold(10'h010, 6, 1'b1);
        hold(10'h000, 2, 1'b1);
        hold(10'h010, 1, 1'b1);
        hold(10'h000, 6, 1'b1);
        check("glitch_kv", 16'(kv_count), 16'd1);
        check("glitch_d", digits(), 16'h0784);

        // Clear on the accept edge.
        kv_count = 0;
        hold(10'h040, 3, 1'b1);
        tick(10'h040, 1'b1, 1'b1, 1'b0);
        check("clracc_d", digits(), 16'h0000);
        check("clracc_kv", 16'(bus.key_valid), 16'd0);
        hold(10'h040, 3, 1'b1);
        hold(10'h000, 5, 1'b1);
        check("clracc_noreacc", 16'(kv_count), 16'd0);
        press(2);

        // Enable low blocks entry; clear still works.
        kv_count = 0;
        hold(10'h200, 10, 1'b0);
        hold(10'h000, 5, 1'b0);
        check("dis_kv", 16'(kv_count), 16'd0);
        check("dis_d", digits(), 16'h0002);
        tick(10'h000, 1'b0, 1'b1, 1'b0);
        check("dis_clr", digits(), 16'h0000);
        check("dis_clr_ez", 16'(bus.entry_zero), 16'd1);

        // Reset mid-hold: key re-accepted after reset.
        hold(10'h008, 6, 1'b1);
        tick(10'h008, 1'b1, 1'b0, 1'b1);
        hold(10'h008, 4, 1'b1);
        check("rst_mid_reacc", digits(), 16'h0003);
        hold(10'h000, 5, 1'b1);

        // Randomized segments.
        for (int seg = 0; seg < 400; seg++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60)      kp = 10'(1 << $urandom_range(0, 9));
            else if (r < 85) kp = '0;
            else             kp = 10'(1 << $urandom_range(0, 4)) | 10'(1 << $urandom_range(5, 9));
            dur = $urandom_range(1, 10);
            en  = ($urandom_range(0, 19) != 0);
            for (int c = 0; c < dur; c++)
                tick(kp, en, ($urandom_range(0, 29) == 0),
                     (c == 0) && ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_digit_loader.md
# timer_digit_loader

Keypad entry stage of the microwave timer input path. It debounces the 10-key keypad, encodes one accepted key per press into BCD, and shifts it into a four-digit MM:SS entry register. The register feeds the timer-input multiplexer, which chooses between operator entry and the running countdown value. `entry_zero` lets the control FSM refuse a start with an empty time.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive identical samples required to accept a press or a release. Legal range 2..255.
- `clk` input, 1 bit: system clock. All state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `enable` input, 1 bit: entry allowed. Driven low by control while cooking.
- `clear_entry` input, 1 bit: synchronous clear of all digits (cancel key).
- `keypad` input, 10 bits: one line per key. Bit n is key n. High means pressed.
- `sec_ones` output, 4 bits: BCD seconds units.
- `sec_tens` output, 4 bits: BCD seconds tens.
- `min_ones` output, 4 bits: BCD minutes units.
- `min_tens` output, 4 bits: BCD minutes tens.
- `key_valid` output, 1 bit: one-cycle pulse when a digit is shifted in.
- `entry_zero` output, 1 bit: high when all four digits are 0.

Clock is `clk`. Reset is `reset`, synchronous and active-high. Single clock domain. `keypad` is already synchronised upstream.

## Operation
- **Sample classification** (every edge):
  - VALID(d): exactly one keypad bit set. d is its index, 0..9.
  - NONE: all bits zero.
  - MULTI: two or more bits set. MULTI is treated as NONE for acceptance, but it does not count toward release.
- **FSM states:** IDLE, DEBOUNCE, HELD, RELEASE. There is one counter, `cnt`, 8 bits, saturating.
- **IDLE:**
  - VALID(d): latch `code` <= d, set `cnt` = 1, go to DEBOUNCE.
  - Otherwise: stay in IDLE.
- **DEBOUNCE:**
  - VALID with the same code: `cnt`++.
  - VALID with a different code: reload `code`, set `cnt` = 1.
  - NONE or MULTI: go to IDLE.
  - When the sample makes `cnt` reach `DEBOUNCE_CYCLES`, accept the key on that edge and go to HELD.
- **HELD:**
  - NONE: set `cnt` = 1, go to RELEASE.
  - Anything else: stay in HELD. There is no auto-repeat.
- **RELEASE:**
  - NONE: `cnt`++. Go to IDLE when `cnt` reaches `DEBOUNCE_CYCLES`.
  - Any non-NONE sample: return to HELD.
- **Accept action:**
  - Shift `min_tens` <= `min_ones` <= `sec_tens` <= `sec_ones` <= `code`. The old `min_tens` is discarded.
  - `key_valid` is high for exactly the following cycle.
  - No range limit is applied: `sec_tens` may hold 6..9. Normalisation belongs downstream.
- **`clear_entry`:**
  - All digits go to 0 on the next edge.
  - Beats a simultaneous accept: the digit is discarded, `key_valid` stays 0, and the FSM still moves to HELD so the key is not re-accepted.
- **`enable` low:**
  - FSM is forced to IDLE, `cnt` to 0, `key_valid` to 0.
  - Digits hold their value.
  - `clear_entry` still works.
- **`entry_zero`:** registered. It equals the NOR of all digit bits as they stand after the edge.

## Timing
- **Reset values:**
  - All digits 0.
  - `key_valid` 0.
  - `entry_zero` 1.
  - FSM in IDLE, `cnt` 0, `code` 0.
  - Reset beats `enable`, `clear_entry` and `keypad`.
- **Reset mid-operation:** any state returns to IDLE. A key still held after reset goes through a full debounce from IDLE and is accepted again.
- **Acceptance latency:**
  - The first VALID sample is at edge k. Digits and `key_valid` update on edge k+`DEBOUNCE_CYCLES`-1.
  - With the default of 4, `key_valid` is high in the cycle after edge k+3.
- **Release latency:** `DEBOUNCE_CYCLES` NONE edges. The earliest next VALID sample is on the edge after the return to IDLE.
- **Minimum press-to-press spacing:** 2×`DEBOUNCE_CYCLES` edges plus the HELD dwell.
- **`entry_zero` timing:** updates on the same edge as the digits.
- **Simultaneous clear and accept:** resolved as described under `clear_entry`.
- **`enable` dropping during DEBOUNCE:** no accept occurs.

## Test plan
- **Reset:** assert `reset` 2 cycles with `keypad`=10'h020.
  - During reset: all digits 0, `entry_zero`=1, `key_valid`=0.
  - After release: key 5 is accepted 4 edges later.
- **Single press:** `keypad`=bit 5 for 6 cycles, then 0.
  - `sec_ones`=5.
  - `key_valid` high exactly 1 cycle, after edge 4.
  - `entry_zero` falls on the same edge.
- **Entry sequence:** clean presses 1, 3, 0, 0, 7.
  - After four presses: digits read 13:00 (`min_tens`=1, `min_ones`=3, `sec_tens`=0, `sec_ones`=0).
  - After the fifth press: 30:07, with the leading 1 shifted out.
- **Bounce and invalid input:**
  - Key 2 pressed for 3 cycles, then 0: no change.
  - Bits 2 and 4 pressed together for 10 cycles: no change.
  - Key 8 held for 50 cycles: exactly one `key_valid`.
- **Release glitch:** press 4 (accepted), release 2 cycles, bit 4 high 1 cycle, then release 4+ cycles. Only one accept occurs.
- **Clear and enable:**
  - `clear_entry` pulsed on the accept edge: digits 0, no `key_valid`.
  - `enable`=0 while key 9 is held 10 cycles: no change, digits hold.
  - `clear_entry` with `enable`=0: digits still go to 0.
